// File: rtl/branch_predictor_bht.sv
// Branch history table with tagged target buffer for the single-issue core.
//
// The IF stage looks up a fetch PC combinationally and gets a taken/not-taken
// prediction plus a target. The EX stage returns the resolved outcome of a
// conditional branch. The tables train on that outcome, and a registered
// one-cycle redirect is raised when the carried prediction was wrong.
//
// Ports:
//   clk, rst_n        : core clock (rising edge), asynchronous active-low reset
//   if_pc             : fetch PC being looked up
//   pred_taken        : combinational taken prediction for if_pc
//   pred_target       : predicted target (if_pc+4 when not predicted taken)
//   ex_valid          : a conditional branch resolves in EX this cycle
//   ex_pc             : PC of the resolving branch
//   ex_taken          : actual outcome
//   ex_target         : actual taken target
//   ex_pred_taken     : prediction carried down the pipe with the branch
//   ex_pred_target    : target carried down the pipe with the branch
//   redirect          : registered one-cycle flush/refetch pulse
//   redirect_pc       : refetch address, holds its value between pulses
//   stat_branches     : resolved-branch count (wraps)
//   stat_mispredicts  : mispredict count (wraps)
//
// Update handshake: there is no backpressure. Every cycle with ex_valid=1 is
// one resolved branch, consumed at that cycle's rising edge; ex_* are ignored
// when ex_valid=0.
module branch_predictor_bht #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8,
  parameter logic [1:0]  CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  // Table storage
  logic [1:0]          r_cnt    [ENTRIES];
  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];

  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Lookup side
  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;

  assign w_if_idx = if_pc[INDEX_BITS+1:2];
  assign w_if_tag = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  // Reads the registered tables only, so a same-cycle update to this index
  // is not visible until the next cycle.
  assign pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

  // Update side
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_ex_hit;
  logic [1:0]            w_ex_cnt_cur;
  logic [1:0]            w_ex_cnt_next;
  logic                  w_mispredict;

  assign w_ex_idx     = ex_pc[INDEX_BITS+1:2];
  assign w_ex_tag     = ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_cnt_cur = r_cnt[w_ex_idx];

  assign w_mispredict = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_pred_target != ex_target)));

  // Counter next value: a miss reallocates the entry starting at the weak
  // state of the observed direction; a hit saturates in [00, 11].
  always_comb begin
    w_ex_cnt_next = w_ex_cnt_cur;
    if (!w_ex_hit) begin
      w_ex_cnt_next = ex_taken ? 2'b10 : 2'b01;
    end else if (ex_taken) begin
      if (w_ex_cnt_cur != 2'b11) w_ex_cnt_next = w_ex_cnt_cur + 2'd1;
    end else begin
      if (w_ex_cnt_cur != 2'b00) w_ex_cnt_next = w_ex_cnt_cur - 2'd1;
    end
  end

  // Counters and valid bits carry reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
      r_valid <= '0;
    end else if (ex_valid) begin
      r_cnt[w_ex_idx]   <= w_ex_cnt_next;
      r_valid[w_ex_idx] <= 1'b1;
    end
  end

  // Tags and targets are meaningless until valid is set, so they need no
  // reset. Rewriting the tag on a hit is harmless (same value).
  always_ff @(posedge clk) begin
    if (ex_valid) begin
      r_tag[w_ex_idx] <= w_ex_tag;
      if (ex_taken) r_target[w_ex_idx] <= ex_target;
    end
  end

  // Redirect pulse and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect         <= 1'b0;
      r_redirect_pc      <= 32'd0;
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc      <= ex_taken ? ex_target : (ex_pc + 32'd4);
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
      if (ex_valid) r_stat_branches <= r_stat_branches + 32'd1;
    end
  end

  assign redirect         = r_redirect;
  assign redirect_pc      = r_redirect_pc;
  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 64 entries, counters as plain ints in 0..3
  int          m_cnt    [64];
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  logic        m_redirect;
  logic [31:0] m_redirect_pc;
  logic [31:0] m_branches;
  logic [31:0] m_mispred;
  logic [31:0] exp_q[$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_cnt[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_redirect    = 1'b0;
    m_redirect_pc = 32'd0;
    m_branches    = 32'd0;
    m_mispred     = 32'd0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    t   = hit && (m_cnt[i] >= 2);
    tgt = t ? m_target[i] : pc + 32'd4;
  endfunction

  // Applies the current ex_* inputs as one clock edge of the model.
  function automatic void model_update();
    int i;
    bit hit, mis;
    m_redirect = 1'b0;
    if (!ex_valid) return;
    i   = idx_of(ex_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
    mis = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target);
    if (hit) begin
      m_cnt[i] = ex_taken ? ((m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1)
                          : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(ex_pc);
      m_cnt[i]   = ex_taken ? 2 : 1;
    end
    if (ex_taken) m_target[i] = ex_target;
    m_redirect = mis;
    if (mis) begin
      m_redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      m_mispred     = m_mispred + 32'd1;
    end
    m_branches = m_branches + 32'd1;
  endfunction

  // Driver
  task automatic drive(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                       input logic et, input logic [31:0] etgt, input logic ept,
                       input logic [31:0] eptgt);
    if_pc          = ipc;
    ex_valid       = ev;
    ex_pc          = epc;
    ex_taken       = et;
    ex_target      = etgt;
    ex_pred_taken  = ept;
    ex_pred_target = eptgt;
  endtask

  // Directed vector table
  typedef struct {
    logic [31:0] ipc;
    logic        ev;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic        x_pt;
    logic [31:0] x_ptgt;
    logic        x_rd;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                              input logic et, input logic [31:0] etgt, input logic ept,
                              input logic [31:0] eptgt, input logic x_pt, input logic [31:0] x_ptgt,
                              input logic x_rd, input logic [31:0] x_rpc);
    vec_t v;
    v.ipc = ipc; v.ev = ev; v.epc = epc; v.et = et; v.etgt = etgt; v.ept = ept;
    v.eptgt = eptgt; v.x_pt = x_pt; v.x_ptgt = x_ptgt; v.x_rd = x_rd; v.x_rpc = x_rpc;
    return v;
  endfunction

  initial begin
    logic        mt;
    logic [31:0] mtgt;
    logic [31:0] pool_pc [8];
    vec_t        v;

    // Cold start and training/saturation of 0x100
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
    // One taken from 00 must leave it at 01 (still not taken)
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h200));
    // Aliasing: 0x200 shares the index with 0x100
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h200));
    // Same-cycle lookup of the index being written sees the old entry
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 32'h500, 0, 32'h0,   0, 32'h304, 1, 32'h500));
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h500));
    // Correct prediction, then target-only mispredict
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 32'h400, 1, 32'h400, 1, 32'h500, 0, 32'h500));
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 32'h600, 1, 32'h400, 1, 32'h400, 1, 32'h600));
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 32'h600));
    // PC+4 wrap
    vecs.push_back(mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 0, 32'h0, 1, 32'h0));

    // Reset
    rst_n = 1'b0;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h104);
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_branches", stat_branches, 32'd0);
    chk("reset_mispredicts", stat_mispredicts, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.ipc, v.ev, v.epc, v.et, v.etgt, v.ept, v.eptgt);
      #1;
      chk($sformatf("vec%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, v.x_pt});
      chk($sformatf("vec%0d_pred_target", i), pred_target, v.x_ptgt);
      @(posedge clk);
      model_update();
      #1;
      chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, v.x_rd});
      chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, v.x_rpc);
      chk($sformatf("vec%0d_branches", i), stat_branches, m_branches);
      chk($sformatf("vec%0d_mispredicts", i), stat_mispredicts, m_mispred);
      @(negedge clk);
    end

    // Asynchronous reset while a redirect pulse is being driven
    drive(32'h300, 1, 32'h300, 0, 32'h0, 1, 32'h600);
    @(posedge clk);
    #1;
    chk("pre_reset_redirect", {31'd0, redirect}, 32'd1);
    #2;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("async_reset_redirect", {31'd0, redirect}, 32'd0);
    chk("async_reset_redirect_pc", redirect_pc, 32'd0);
    chk("async_reset_branches", stat_branches, 32'd0);
    chk("async_reset_mispredicts", stat_mispredicts, 32'd0);
    chk("async_reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_reset_pred_target", pred_target, 32'h304);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase against the model; small PC pool to force hits/aliases
    for (int k = 0; k < 8; k++)
      pool_pc[k] = (32'($urandom_range(0, 3)) << 2) + (32'($urandom_range(0, 1)) << 8)
                   + ((k == 7) ? 32'hFFFF_FFFC : 32'd0);
    for (int c = 0; c < 400; c++) begin
      logic [31:0] epc;
      logic        et;
      logic [31:0] etgt;
      logic        ept;
      logic [31:0] eptgt;
      epc  = pool_pc[$urandom_range(0, 7)];
      et   = 1'($urandom_range(0, 1));
      etgt = 32'($urandom_range(1, 4)) << 12;
      if ($urandom_range(0, 3) != 0) model_predict(epc, ept, eptgt);
      else begin
        ept   = 1'($urandom_range(0, 1));
        eptgt = 32'($urandom_range(1, 4)) << 12;
      end
      drive(pool_pc[$urandom_range(0, 7)], 1'($urandom_range(0, 4) != 0), epc, et, etgt, ept, eptgt);
      #1;
      model_predict(if_pc, mt, mtgt);
      chk("rnd_pred_taken", {31'd0, pred_taken}, {31'd0, mt});
      chk("rnd_pred_target", pred_target, mtgt);
      @(posedge clk);
      model_update();
      if (m_redirect) exp_q.push_back(m_redirect_pc);
      #1;
      chk("rnd_redirect", {31'd0, redirect}, {31'd0, m_redirect});
      if (redirect) begin
        if (exp_q.size() == 0) chk("rnd_redirect_unexpected", {31'd0, redirect}, 32'd0);
        else chk("rnd_redirect_pc_sb", redirect_pc, exp_q.pop_front());
      end
      chk("rnd_redirect_pc", redirect_pc, m_redirect_pc);
      chk("rnd_branches", stat_branches, m_branches);
      chk("rnd_mispredicts", stat_mispredicts, m_mispred);
      @(negedge clk);
    end
    chk("rnd_redirect_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
